sindrv_resp: RTL and testbench

Responder (slave) end of the `mdriver_int` single-word transfer protocol. It accepts write and read requests issued by a driver on `exec`, services them from a local 64 x 32-bit word memory mapped at window 0x100–0x1FF, and acknowledges each request with a one-cycle `fin` pulse after a programmable wait. It also exposes a registered debug read port and transfer/error counters, so benches and downstream consumers can inspect the captured sample stream.

---
 rtl/mdrv_pkg.sv | 15 +
 rtl/mdriver_int.sv | 20 ++
 rtl/sindrv_resp_ram.sv | 41 ++++
 rtl/sindrv_resp.sv | 109 ++++++++++
 tb/tb_sindrv_resp.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mdrv_pkg.sv
// Shared types and constants for the mdriver_int single-word transfer protocol.
package mdrv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } resp_state_t;

    localparam int MDRV_ADDR_W  = 9;
    localparam int MDRV_DATA_W  = 32;
    localparam int MDRV_WIN_BIT = 8;
    localparam int MDRV_IDX_W   = 6;

endpackage

// File: rtl/mdriver_int.sv
// mdriver_int bus: driver issues exec/we/address/data, responder returns fin/err/data.
interface mdriver_int
    import mdrv_pkg::*;
(
    input logic clk,
    input logic nreset
);
    logic                   exec;
    logic                   we;
    logic [MDRV_ADDR_W-1:0] si_address;
    logic [MDRV_DATA_W-1:0] si_data;
    logic [MDRV_DATA_W-1:0] so_data;
    logic                   fin;
    logic                   err;

    modport slave (
        input  clk, nreset, exec, we, si_address, si_data,
        output so_data, fin, err
    );
endinterface

// File: rtl/sindrv_resp_ram.sv
// 64x32 word store: one synchronous write port, two registered read ports.
// Latency: reads 1 cycle; a same-cycle write is seen by readers the cycle after.
// Backpressure: none, every port is serviced every cycle.
module sindrv_resp_ram
    import mdrv_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   nreset,
    input  logic                   wr_en,
    input  logic [AW-1:0]          wr_addr,
    input  logic [MDRV_DATA_W-1:0] wr_data,
    input  logic                   rd_en,
    input  logic [AW-1:0]          rd_addr,
    output logic [MDRV_DATA_W-1:0] rd_data,
    input  logic [AW-1:0]          dbg_addr,
    output logic [MDRV_DATA_W-1:0] dbg_data
);
    logic [MDRV_DATA_W-1:0] mem [DEPTH];

    // Contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            rd_data  <= '0;
            dbg_data <= '0;
        end else begin
            if (rd_en) begin
                rd_data <= mem[rd_addr];
            end
            dbg_data <= mem[dbg_addr];
        end
    end
endmodule

// File: rtl/sindrv_resp.sv
// Responder for mdriver_int: serves the 0x100-0x1FF word window from local memory.
// Latency: fin WAIT_CYC+1 cycles after exec is sampled in IDLE.
// Backpressure: one request in flight; exec outside IDLE is ignored.
module sindrv_resp
    import mdrv_pkg::*;
#(
    parameter int WAIT_CYC = 2,
    parameter int DEPTH    = 64
) (
    mdriver_int.slave              bus,
    input  logic [MDRV_IDX_W-1:0]  dbg_addr,
    output logic [MDRV_DATA_W-1:0] dbg_data,
    output logic [15:0]            wr_count,
    output logic [7:0]             err_count
);
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;

    resp_state_t            state, state_nxt;
    logic [3:0]             wait_cnt;
    logic                   req_we;
    logic                   req_win;
    logic [MDRV_IDX_W-1:0]  req_idx;
    logic [MDRV_DATA_W-1:0] req_data;
    logic                   err_q;

    logic                   cur_win;
    logic [MDRV_IDX_W-1:0]  cur_idx;
    logic                   ram_wr_en;
    logic                   ram_rd_en;
    logic [MDRV_DATA_W-1:0] ram_rd_data;
    logic                   unused_addr_bits;

    assign unused_addr_bits = &{1'b0, bus.si_address[1:0]};

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.exec) state_nxt = (WAIT_CYC > 0) ? WAIT : ACK;
            WAIT: if (wait_cnt == 4'd0) state_nxt = ACK;
            ACK:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // With WAIT_CYC=0 the read address must come straight from the bus.
    always_comb begin
        cur_win = req_win;
        cur_idx = req_idx;
        if (state == IDLE) begin
            cur_win = bus.si_address[MDRV_WIN_BIT];
            cur_idx = bus.si_address[7:2];
        end
    end

    // Gating on nreset keeps a reset sampled in ACK from committing the write.
    assign ram_wr_en = (state == ACK) && bus.nreset && req_we && req_win;
    assign ram_rd_en = (state_nxt == ACK);

    always_ff @(posedge bus.clk) begin
        if (!bus.nreset) begin
            state     <= IDLE;
            wait_cnt  <= 4'd0;
            req_we    <= 1'b0;
            req_win   <= 1'b0;
            req_idx   <= '0;
            req_data  <= '0;
            err_q     <= 1'b0;
            wr_count  <= 16'd0;
            err_count <= 8'd0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && bus.exec) begin
                req_we   <= bus.we;
                req_win  <= bus.si_address[MDRV_WIN_BIT];
                req_idx  <= bus.si_address[7:2];
                req_data <= bus.si_data;
                wait_cnt <= WAIT_LOAD;
            end else if (state == WAIT && wait_cnt != 4'd0) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
            if (state_nxt == ACK) begin
                err_q <= !cur_win;
            end
            if (ram_wr_en) begin
                wr_count <= wr_count + 16'd1;
            end
            if (state == ACK && err_q && err_count != 8'hFF) begin
                err_count <= err_count + 8'd1;
            end
        end
    end

    sindrv_resp_ram #(.DEPTH(DEPTH)) u_ram (
        .clk      (bus.clk),
        .nreset   (bus.nreset),
        .wr_en    (ram_wr_en),
        .wr_addr  (req_idx),
        .wr_data  (req_data),
        .rd_en    (ram_rd_en),
        .rd_addr  (cur_idx),
        .rd_data  (ram_rd_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    assign bus.fin     = (state == ACK);
    assign bus.err     = err_q;
    assign bus.so_data = err_q ? '0 : ram_rd_data;
endmodule

// File: tb/tb_sindrv_resp.sv
// Bench for sindrv_resp: transaction-level model with a per-cycle compare on the
// WAIT_CYC=2 instance, and directed checks on a WAIT_CYC=0 instance.
module tb_sindrv_resp;
    logic clk = 1'b0;
    logic nreset;
    always #5 clk = ~clk;

    mdriver_int bus1 (.clk(clk), .nreset(nreset));
    mdriver_int bus2 (.clk(clk), .nreset(nreset));

    logic [5:0]  dbg_addr1, dbg_addr2;
    logic [31:0] dbg_data1, dbg_data2;
    logic [15:0] wr_count1, wr_count2;
    logic [7:0]  err_count1, err_count2;

    sindrv_resp #(.WAIT_CYC(2), .DEPTH(64)) dut1 (
        .bus(bus1), .dbg_addr(dbg_addr1), .dbg_data(dbg_data1),
        .wr_count(wr_count1), .err_count(err_count1)
    );
    sindrv_resp #(.WAIT_CYC(0), .DEPTH(64)) dut2 (
        .bus(bus2), .dbg_addr(dbg_addr2), .dbg_data(dbg_data2),
        .wr_count(wr_count2), .err_count(err_count2)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit run = 1'b0;

    typedef struct {
        int          fin_cyc;
        bit          we;
        logic [8:0]  addr;
        logic [31:0] data;
    } req_t;

    req_t        q[$];
    logic [31:0] mmem[64];
    bit          mknown[64];
    int          m_wr = 0;
    int          m_err = 0;
    logic [31:0] dbg_exp = '0;
    bit          dbg_known = 1'b0;
    int          last_fin = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Per-cycle compare of instance 1 against the transaction model.
    always @(negedge clk) begin
        bit   exp_fin;
        req_t r;
        int   idx;
        exp_fin = (q.size() > 0) && (q[0].fin_cyc == cyc);
        r = '{0, 1'b0, 9'h0, 32'h0};
        if (exp_fin) r = q.pop_front();
        idx = int'(r.addr[7:2]);
        if (run) begin
            chk("fin", {31'b0, bus1.fin}, {31'b0, exp_fin});
            if (bus1.fin) last_fin = cyc;
            if (exp_fin) begin
                if (!r.addr[8]) begin
                    chk("err_flag", {31'b0, bus1.err}, 32'd1);
                    chk("err_so_data", bus1.so_data, 32'd0);
                end else begin
                    chk("ok_flag", {31'b0, bus1.err}, 32'd0);
                    if (!r.we && mknown[idx]) chk("rd_data", bus1.so_data, mmem[idx]);
                end
            end
            chk("wr_count", {16'b0, wr_count1}, 32'(m_wr & 16'hFFFF));
            chk("err_count", {24'b0, err_count1}, 32'(m_err));
            if (dbg_known) chk("dbg_data", dbg_data1, dbg_exp);
        end
        dbg_exp   = mmem[dbg_addr1];
        dbg_known = mknown[dbg_addr1];
        if (exp_fin && nreset) begin
            if (!r.addr[8]) begin
                if (m_err < 255) m_err++;
            end else if (r.we) begin
                mmem[idx]   = r.data;
                mknown[idx] = 1'b1;
                m_wr++;
            end
        end
        if (!nreset) begin
            q.delete();
            m_wr      = 0;
            m_err     = 0;
            dbg_exp   = '0;
            dbg_known = 1'b1;
        end
    end

    task automatic req1(input bit we, input logic [8:0] addr, input logic [31:0] data,
                        output int issue);
        int t;
        @(posedge clk); #1;
        bus1.exec = 1'b1;
        bus1.we = we;
        bus1.si_address = addr;
        bus1.si_data = data;
        issue = cyc;
        q.push_back('{cyc + 3, we, addr, data});
        @(posedge clk); #1;
        bus1.exec = 1'b0;
        t = 0;
        while (q.size() != 0 && t < 40) begin
            @(posedge clk);
            t++;
        end
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL fin_timeout: got no fin expected fin within 40 cycles");
            q.delete();
        end
    endtask

    task automatic set_dbg(input logic [5:0] a);
        @(posedge clk); #1;
        dbg_addr1 = a;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic reset_pulse();
        @(posedge clk); #1;
        nreset = 1'b0;
        @(posedge clk); #1;
        nreset = 1'b1;
    endtask

    initial begin
        int c;
        int nfin;
        nreset = 1'b0;
        bus1.exec = 1'b0; bus1.we = 1'b0; bus1.si_address = '0; bus1.si_data = '0;
        bus2.exec = 1'b0; bus2.we = 1'b0; bus2.si_address = '0; bus2.si_data = '0;
        dbg_addr1 = '0;
        dbg_addr2 = '0;
        repeat (3) @(posedge clk);
        #1;
        nreset = 1'b1;
        run = 1'b1;
        @(negedge clk);
        chk("rst_fin", {31'b0, bus1.fin}, 32'd0);
        chk("rst_err", {31'b0, bus1.err}, 32'd0);
        chk("rst_so_data", bus1.so_data, 32'd0);
        chk("rst_dbg", dbg_data1, 32'd0);
        chk("rst_wr_count", {16'b0, wr_count1}, 32'd0);
        chk("rst_err_count", {24'b0, err_count1}, 32'd0);

        // Write then read back, including the ignored byte-offset bits.
        req1(1'b1, 9'h104, 32'hDEADBEEF, c);
        chk("wr_latency", 32'(last_fin - c), 32'd3);
        @(negedge clk);
        chk("wr_count_1", {16'b0, wr_count1}, 32'd1);
        set_dbg(6'd1);
        chk("dbg_word1", dbg_data1, 32'hDEADBEEF);
        req1(1'b0, 9'h104, 32'h0, c);
        @(negedge clk);
        chk("rd_hold_104", bus1.so_data, 32'hDEADBEEF);
        req1(1'b0, 9'h105, 32'h0, c);
        @(negedge clk);
        chk("rd_hold_105", bus1.so_data, 32'hDEADBEEF);

        // Out-of-window write leaves memory alone; error counter saturates.
        req1(1'b1, 9'h1FC, 32'h12345678, c);
        req1(1'b1, 9'h0FC, 32'hCAFEF00D, c);
        @(negedge clk);
        chk("err_hold", {31'b0, bus1.err}, 32'd1);
        chk("err_count_1", {24'b0, err_count1}, 32'd1);
        set_dbg(6'd63);
        chk("word63_kept", dbg_data1, 32'h12345678);
        for (int i = 0; i < 299; i++) req1(1'b1, 9'h0FC, 32'(i), c);
        @(negedge clk);
        chk("err_count_sat", {24'b0, err_count1}, 32'hFF);

        // Driver-style stream over the whole window, observed on word 1.
        reset_pulse();
        set_dbg(6'd1);
        for (int i = 0; i < 64; i++) req1(1'b1, 9'(9'h100 + i * 4), 32'(i), c);
        @(negedge clk);
        chk("wr_count_64", {16'b0, wr_count1}, 32'd64);
        req1(1'b1, 9'(9'h1FC + 9'h4), 32'hFFFF0000, c);
        @(negedge clk);
        chk("wrap_err", {31'b0, bus1.err}, 32'd1);
        for (int i = 0; i < 64; i++) begin
            set_dbg(6'(i));
            chk("stream_word", dbg_data1, 32'(i));
        end

        // Reset during WAIT of a write aborts it.
        @(posedge clk); #1;
        bus1.exec = 1'b1; bus1.we = 1'b1; bus1.si_address = 9'h108; bus1.si_data = 32'h00000BAD;
        q.push_back('{cyc + 3, 1'b1, 9'h108, 32'h00000BAD});
        @(posedge clk); #1;
        bus1.exec = 1'b0;
        nreset = 1'b0;
        @(posedge clk); #1;
        nreset = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("abort_wr_count", {16'b0, wr_count1}, 32'd0);
        set_dbg(6'd2);
        chk("abort_word2", dbg_data1, 32'd2);
        req1(1'b0, 9'h108, 32'h0, c);
        chk("post_rst_latency", 32'(last_fin - c), 32'd3);
        @(negedge clk);
        chk("post_rst_read", bus1.so_data, 32'd2);

        // WAIT_CYC=0 instance with exec held for 10 cycles.
        @(posedge clk); #1;
        bus2.exec = 1'b1; bus2.we = 1'b1; bus2.si_address = 9'h110; bus2.si_data = 32'h55;
        c = cyc;
        nfin = 0;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            chk("held_fin", {31'b0, bus2.fin},
                {31'b0, (k == 1 || k == 3 || k == 5 || k == 7 || k == 9)});
            if (bus2.fin) nfin++;
            @(posedge clk); #1;
            if (cyc == c + 10) bus2.exec = 1'b0;
        end
        chk("held_fin_count", 32'(nfin), 32'd5);
        chk("held_wr_count", {16'b0, wr_count2}, 32'd5);
        dbg_addr2 = 6'd4;
        @(posedge clk);
        @(negedge clk);
        chk("held_word4", dbg_data2, 32'h55);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
